// File: rtl/cdr_tx_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cdr_tx_pkg : shared types and constants for the CDR transmit source  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package cdr_tx_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    DATA     = 2'd2
  } tx_state_e;

  // PRBS7 (x^7 + x^6 + 1): feedback taps of a left-shifting 7-bit register.
  localparam int C_PRBS7_TAP_HI = 6;
  localparam int C_PRBS7_TAP_LO = 5;

  // Shared with the receive-side DCO so both ends agree on nominal UI and level.
  localparam logic signed [7:0] C_AMP_DEFAULT     = 8'sd64;
  localparam logic [31:0]       C_FCW_NOM_DEFAULT = 32'h8000_0000;

  function automatic logic prbs7_fb(input logic [6:0] state);
    return state[C_PRBS7_TAP_HI] ^ state[C_PRBS7_TAP_LO];
  endfunction

endpackage
`default_nettype wire

// File: rtl/nco_wrap.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | nco_wrap : phase accumulator with carry-out strobe                   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module nco_wrap #(
  parameter int PHASE_BITS = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [PHASE_BITS-1:0] fcw,
  output logic                  strobe
);

  logic [PHASE_BITS-1:0] r_phase;
  logic [PHASE_BITS:0]   w_sum;

  assign w_sum  = {1'b0, r_phase} + {1'b0, fcw};
  assign strobe = w_sum[PHASE_BITS];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_phase <= '0;
    end else begin
      r_phase <= w_sum[PHASE_BITS-1:0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/cdr_tx_symbol_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cdr_tx_symbol_gen : NCO-timed NRZ serializer with preamble/PRBS fill |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module cdr_tx_symbol_gen
  import cdr_tx_pkg::*;
#(
  parameter int                PHASE_BITS   = 32,
  parameter logic [PHASE_BITS-1:0] FCW_NOM  = PHASE_BITS'(C_FCW_NOM_DEFAULT),
  parameter logic signed [7:0] AMP          = C_AMP_DEFAULT,
  parameter int                PREAMBLE_LEN = 16,
  parameter logic [6:0]        PRBS_SEED    = 7'h7F
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic signed [31:0] fcw_ofs,
  input  logic [7:0]         s_data,
  input  logic               s_last,
  input  logic               s_valid,
  output logic               s_ready,
  output logic               sym_en,
  output logic signed [7:0]  y_n,
  output logic               tx_bit,
  output logic               busy,
  output logic               underrun
);

  localparam logic [7:0] C_PRE_LEN = 8'(PREAMBLE_LEN);

  logic [PHASE_BITS-1:0] r_fcw;
  logic                  w_sym_en;

  tx_state_e         r_state, w_state_nxt;
  logic [6:0]        r_prbs;
  logic [7:0]        r_cnt;
  logic [3:0]        r_bitcnt;
  logic [7:0]        r_shreg;
  logic              r_cur_last;
  logic              r_hold_full;
  logic [7:0]        r_hold_data;
  logic              r_hold_last;
  logic              r_tx_bit;
  logic signed [7:0] r_y;
  logic              r_underrun;

  logic w_prbs_fb;
  logic w_bit;
  logic w_prbs_adv;
  logic w_load;
  logic w_pre_start;
  logic w_pre_step;
  logic w_shift;
  logic w_underrun_set;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fcw <= FCW_NOM;
    end else begin
      r_fcw <= FCW_NOM + PHASE_BITS'(fcw_ofs);
    end
  end

  nco_wrap #(
    .PHASE_BITS (PHASE_BITS)
  ) u_nco (
    .clk    (clk),
    .rst_n  (rst_n),
    .fcw    (r_fcw),
    .strobe (w_sym_en)
  );

  assign w_prbs_fb = prbs7_fb(r_prbs);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_sym_en) begin
      case (r_state)
        IDLE:     if (r_hold_full) w_state_nxt = PREAMBLE;
        PREAMBLE: if (r_cnt >= C_PRE_LEN) w_state_nxt = DATA;
        DATA:     if (r_bitcnt == 4'd8 && !r_hold_full) w_state_nxt = IDLE;
        default:  w_state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    w_bit          = r_tx_bit;
    w_prbs_adv     = 1'b0;
    w_load         = 1'b0;
    w_pre_start    = 1'b0;
    w_pre_step     = 1'b0;
    w_shift        = 1'b0;
    w_underrun_set = 1'b0;
    if (w_sym_en) begin
      case (r_state)
        IDLE: begin
          if (r_hold_full) begin
            w_pre_start = 1'b1;
            w_bit       = 1'b1;
          end else begin
            w_prbs_adv = 1'b1;
            w_bit      = w_prbs_fb;
          end
        end
        PREAMBLE: begin
          if (r_cnt < C_PRE_LEN) begin
            w_pre_step = 1'b1;
            w_bit      = ~r_tx_bit;
          end else begin
            w_load = 1'b1;
            w_bit  = r_hold_data[7];
          end
        end
        DATA: begin
          if (r_bitcnt < 4'd8) begin
            w_shift = 1'b1;
            w_bit   = r_shreg[7];
          end else if (r_hold_full) begin
            w_load = 1'b1;
            w_bit  = r_hold_data[7];
          end else begin
            // Frame ends here; PRBS resumes from where it froze at frame start.
            w_prbs_adv     = 1'b1;
            w_bit          = w_prbs_fb;
            w_underrun_set = !r_cur_last;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_prbs      <= PRBS_SEED;
      r_cnt       <= 8'd0;
      r_bitcnt    <= 4'd0;
      r_shreg     <= 8'd0;
      r_cur_last  <= 1'b0;
      r_hold_full <= 1'b0;
      r_hold_data <= 8'd0;
      r_hold_last <= 1'b0;
      r_tx_bit    <= 1'b0;
      r_y         <= 8'sd0;
      r_underrun  <= 1'b0;
    end else begin
      r_underrun <= w_underrun_set;
      if (w_sym_en) begin
        r_tx_bit <= w_bit;
        r_y      <= w_bit ? AMP : -AMP;
      end
      if (w_prbs_adv) begin
        r_prbs <= {r_prbs[5:0], w_prbs_fb};
      end
      if (w_pre_start) begin
        r_cnt <= 8'd1;
      end else if (w_pre_step) begin
        r_cnt <= r_cnt + 8'd1;
      end
      if (w_load) begin
        r_shreg    <= {r_hold_data[6:0], 1'b0};
        r_cur_last <= r_hold_last;
        r_bitcnt   <= 4'd1;
      end else if (w_shift) begin
        r_shreg  <= {r_shreg[6:0], 1'b0};
        r_bitcnt <= r_bitcnt + 4'd1;
      end
      // Drain and accept are mutually exclusive: accept needs the hold empty.
      if (w_load) begin
        r_hold_full <= 1'b0;
      end else if (s_valid && !r_hold_full) begin
        r_hold_full <= 1'b1;
        r_hold_data <= s_data;
        r_hold_last <= s_last;
      end
    end
  end

  assign s_ready  = !r_hold_full;
  assign sym_en   = w_sym_en;
  assign y_n      = r_y;
  assign tx_bit   = r_tx_bit;
  assign busy     = (r_state != IDLE);
  assign underrun = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_cdr_tx_symbol_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_cdr_tx_symbol_gen : randomized bench with behavioural model       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_cdr_tx_symbol_gen;

  localparam logic [31:0] NOM     = 32'h8000_0000;
  localparam int          PRE_LEN = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic signed [31:0] fcw_ofs;
  logic [7:0]        s_data;
  logic              s_last;
  logic              s_valid;
  logic              s_ready;
  logic              sym_en;
  logic signed [7:0] y_n;
  logic              tx_bit;
  logic              busy;
  logic              underrun;

  always #5 clk = ~clk;

  cdr_tx_symbol_gen dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .fcw_ofs  (fcw_ofs),
    .s_data   (s_data),
    .s_last   (s_last),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .sym_en   (sym_en),
    .y_n      (y_n),
    .tx_bit   (tx_bit),
    .busy     (busy),
    .underrun (underrun)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: symbols come from a bit queue; PRBS from the bit recurrence
  // b[n] = b[n-7] ^ b[n-6] seeded by the reset state.
  logic [31:0] m_phase = '0;
  logic [31:0] m_fcw   = NOM;
  bit          m_hold_full, m_hold_last, m_cur_last, m_in_frame, m_underrun, m_bit;
  logic [7:0]  m_hold_data;
  int          m_y, m_fs;
  bit          m_q[$];
  bit          m_ph[$];
  bit          m_log[$];

  function automatic bit m_se();
    logic [32:0] t;
    t = {1'b0, m_phase} + {1'b0, m_fcw};
    return t[32];
  endfunction

  always @(posedge clk) begin
    bit se, acc, b;
    logic [6:0] seed_v;
    se = m_se();
    if (!rst_n) begin
      m_phase = '0; m_fcw = NOM;
      m_hold_full = 0; m_hold_last = 0; m_cur_last = 0; m_in_frame = 0;
      m_underrun = 0; m_bit = 0; m_y = 0; m_fs = 0;
      m_q.delete(); m_log.delete(); m_ph.delete();
      seed_v = 7'h7F;
      for (int i = 6; i >= 0; i--) m_ph.push_back(seed_v[i]);
    end else begin
      acc = s_valid && !m_hold_full;
      m_underrun = 0;
      if (se) begin
        if (m_q.size() == 0) begin
          if (m_in_frame) begin
            if (m_hold_full) begin
              for (int i = 7; i >= 0; i--) m_q.push_back(m_hold_data[i]);
              m_cur_last = m_hold_last;
              m_hold_full = 0;
            end else begin
              m_underrun = !m_cur_last;
              m_in_frame = 0;
            end
          end else if (m_hold_full) begin
            m_in_frame = 1;
            m_cur_last = 0;
            m_fs = m_log.size();
            for (int i = 0; i < PRE_LEN; i++) m_q.push_back(i % 2 == 0);
          end
        end
        if (m_q.size() > 0) begin
          b = m_q.pop_front();
        end else begin
          b = m_ph[m_ph.size()-7] ^ m_ph[m_ph.size()-6];
          m_ph.push_back(b);
        end
        m_bit = b;
        m_y   = b ? 64 : -64;
        m_log.push_back(b);
      end
      if (acc) begin
        m_hold_full = 1; m_hold_data = s_data; m_hold_last = s_last;
      end
      m_phase = m_phase + m_fcw;
      m_fcw   = NOM + fcw_ofs;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("sym_en",   int'(sym_en),   int'(m_se()));
      chk("y_n",      int'(y_n),      m_y);
      chk("tx_bit",   int'(tx_bit),   int'(m_bit));
      chk("busy",     int'(busy),     int'(m_in_frame));
      chk("s_ready",  int'(s_ready),  int'(!m_hold_full));
      chk("underrun", int'(underrun), int'(m_underrun));
    end
  end

  // DUT-side log of levels produced at each strobe, plus an underrun pulse counter.
  int d_log[$];
  bit prev_se = 0;
  int urun_cnt = 0;
  int cyc = 0;
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      d_log.delete();
      prev_se = 0;
    end else begin
      if (prev_se) d_log.push_back(int'(y_n));
      prev_se = sym_en;
      if (underrun === 1'b1) urun_cnt++;
    end
  end

  task automatic send(input logic [7:0] d, input logic l);
    int n = 0;
    s_data = d; s_last = l; s_valid = 1'b1;
    while (s_ready !== 1'b1 && n < 3000) begin
      @(negedge clk); n++;
    end
    if (n >= 3000) chk("send_timeout", 1, 0);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic wait_log(input int n);
    int k = 0;
    while (d_log.size() < n && k < 5000) begin
      @(negedge clk); k++;
    end
    @(negedge clk);
    if (k >= 5000) chk("log_timeout", 1, 0);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy !== 1'b0 && k < 5000) begin
      @(negedge clk); k++;
    end
    if (k >= 5000) chk("idle_timeout", 1, 0);
  endtask

  task automatic check_prbs_start(input string nm);
    int exp7[7];
    exp7 = '{-64, -64, -64, -64, -64, -64, 64};
    wait_log(7);
    for (int i = 0; i < 7; i++) begin
      chk({nm, "_dut"}, d_log[i], exp7[i]);
      chk({nm, "_model"}, m_log[i] ? 64 : -64, exp7[i]);
    end
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [15:0] frame_bits;
    int fs, u0, t0, stamps[4], k;
    rst_n = 1'b0; fcw_ofs = '0; s_data = '0; s_last = 1'b0; s_valid = 1'b0;

    @(negedge clk);
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_y_n",   int'(y_n),     0);
    chk("rst_sym_en", int'(sym_en), 0);
    chk("rst_ready", int'(s_ready), 1);
    chk("rst_busy",  int'(busy),    0);

    rst_n = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      chk("sym_en_cadence", int'(sym_en), i % 2);
    end

    check_prbs_start("prbs_first7");

    // Frame 0xA5 then 0x3C(last): preamble, data bits back to back, then PRBS.
    u0 = urun_cnt;
    send(8'hA5, 1'b0);
    send(8'h3C, 1'b1);
    wait_idle();
    fs = m_fs;
    wait_log(fs + 33);
    for (int i = 0; i < PRE_LEN; i++)
      chk("preamble", d_log[fs+i], (i % 2 == 0) ? 64 : -64);
    frame_bits = 16'hA53C;
    for (int i = 0; i < 16; i++)
      chk("frame_bits", d_log[fs+PRE_LEN+i], frame_bits[15-i] ? 64 : -64);
    chk("frame_no_underrun", urun_cnt - u0, 0);

    // Underrun: single byte without last.
    u0 = urun_cnt;
    send(8'hFF, 1'b0);
    repeat (4) @(negedge clk);
    wait_idle();
    repeat (4) @(negedge clk);
    chk("underrun_once", urun_cnt - u0, 1);
    chk("underrun_busy", int'(busy), 0);

    // Frequency offset halves the rate.
    fcw_ofs = -32'sh4000_0000;
    repeat (8) @(negedge clk);
    k = 0; t0 = 0;
    while (k < 4 && t0 < 200) begin
      @(negedge clk); t0++;
      if (sym_en === 1'b1) begin stamps[k] = cyc; k++; end
    end
    chk("fcw_strobes_found", k, 4);
    for (int i = 1; i < 4; i++) chk("fcw_spacing", stamps[i] - stamps[i-1], 4);
    fcw_ofs = '0;
    repeat (6) @(negedge clk);

    // Randomized frames with random gaps and rates.
    for (int f = 0; f < 10; f++) begin
      int nb;
      fcw_ofs = -$signed({1'b0, 31'($urandom_range(0, 32'h6000_0000))});
      nb = $urandom_range(1, 4);
      for (int j = 0; j < nb; j++) begin
        send(8'($urandom), (j == nb - 1));
        repeat ($urandom_range(0, (f % 3 == 0) ? 60 : 6)) @(negedge clk);
      end
      wait_idle();
      repeat ($urandom_range(2, 20)) @(negedge clk);
    end
    fcw_ofs = '0;
    repeat (4) @(negedge clk);

    // Reset in the middle of DATA.
    send(8'h5A, 1'b0);
    send(8'hC3, 1'b1);
    repeat (10) @(negedge clk);
    chk("pre_reset_busy", int'(busy), 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_y_n",  int'(y_n),     0);
    chk("midrst_busy", int'(busy),    0);
    chk("midrst_ready", int'(s_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    check_prbs_start("prbs_restart");
    repeat (20) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
